// File: rtl/outer_frame_sender.sv
// Host-side transmitter for the outer inbound link: one size command per descriptor, then the data words.
// Latency: data pass-through is combinational (0 cycles); with OUTER_SENDER_SKID_EN it is registered (1 cycle).
// Backpressure: cmd waits for cmd_canReceive; data stalls propagate to d_canReceive (through the skid buffer when enabled).
//
// Optional build macro: OUTER_SENDER_SKID_EN inserts a 2-entry registered skid buffer between d and o__in.
//
// Ports:
//   clk, rst                   clock and synchronous active-high reset
//   desc/_isReady/_canReceive  transfer size in 64-bit words (0 = automatic, ends on d_isLast)
//   d/_isReady/_canReceive     host data word stream, d_isLast marks the final word
//   d_isLast                   host end-of-transfer marker, qualifies d
//   cmd/_isReady/_canReceive   size command toward the adapter
//   o__in/_isReady/_canReceive data toward the adapter
//   busy                       a transfer is in progress
//   err                        sticky: d_isLast seen on a non-final word of a sized transfer
module outer_frame_sender #(
  parameter int MAX_WORD_LEN = 15
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [MAX_WORD_LEN-1:0] desc,
  input  logic                    desc_isReady,
  output logic                    desc_canReceive,
  input  logic [63:0]             d,
  input  logic                    d_isReady,
  output logic                    d_canReceive,
  input  logic                    d_isLast,
  output logic [MAX_WORD_LEN-1:0] cmd,
  output logic                    cmd_isReady,
  input  logic                    cmd_canReceive,
  output logic [63:0]             o__in,
  output logic                    o__in_isReady,
  input  logic                    o__in_canReceive,
  output logic                    busy,
  output logic                    err
);

  localparam logic [1:0] ST_IDLE   = 2'd0;
  localparam logic [1:0] ST_ISSUE  = 2'd1;
  localparam logic [1:0] ST_STREAM = 2'd2;

  localparam logic [MAX_WORD_LEN-1:0] CNT_ONE = MAX_WORD_LEN'(1);

  logic [1:0]              r_state;
  logic [MAX_WORD_LEN-1:0] r_size;
  logic [MAX_WORD_LEN-1:0] r_cnt;
  logic                    r_err;

  logic w_idle;
  logic w_issue;
  logic w_stream;
  logic w_desc_fire;
  logic w_cmd_fire;
  logic w_d_fire;
  logic w_auto;
  logic w_d_final;
  logic w_err_set;
  logic w_stream_done;

  assign w_idle   = (r_state == ST_IDLE);
  assign w_issue  = (r_state == ST_ISSUE);
  assign w_stream = (r_state == ST_STREAM);

  assign desc_canReceive = w_idle;
  assign cmd_isReady     = w_issue;
  assign cmd             = w_issue ? r_size : '0;
  assign busy            = ~w_idle;
  assign err             = r_err;

  assign w_desc_fire = desc_isReady & desc_canReceive;
  assign w_cmd_fire  = cmd_isReady & cmd_canReceive;
  assign w_d_fire    = d_isReady & d_canReceive;
  assign w_auto      = (r_size == '0);

  // Final host word: auto mode ends on d_isLast, sized mode ends on the count.
  assign w_d_final = w_d_fire & (w_auto ? d_isLast : (r_cnt == CNT_ONE));
  // An early d_isLast in sized mode is only flagged; the transfer still runs to full count.
  assign w_err_set = w_d_fire & ~w_auto & d_isLast & (r_cnt > CNT_ONE);

`ifdef OUTER_SENDER_SKID_EN
  // Two-entry buffer: r_q0 is the head driving o__in, r_q1 catches a word while the head is stalled.
  logic [63:0] r_q0;
  logic [63:0] r_q1;
  logic [1:0]  r_q_cnt;
  logic        r_final_taken;
  logic        w_out_fire;
  logic [1:0]  w_q_cnt_nxt;

  assign o__in         = r_q0;
  assign o__in_isReady = (r_q_cnt != 2'd0);
  assign w_out_fire    = o__in_isReady & o__in_canReceive;
  // Host side accepts from buffer occupancy only, so d_canReceive does not depend on o__in_canReceive.
  assign d_canReceive  = w_stream & ~r_final_taken & (r_q_cnt != 2'd2);

  always_comb begin
    w_q_cnt_nxt = r_q_cnt;
    if (w_d_fire && !w_out_fire) begin
      w_q_cnt_nxt = r_q_cnt + 2'd1;
    end else if (!w_d_fire && w_out_fire) begin
      w_q_cnt_nxt = r_q_cnt - 2'd1;
    end
  end

  // Leave STREAM only after the final host word is taken and the buffer has drained.
  assign w_stream_done = w_stream & (r_final_taken | w_d_final) & (w_q_cnt_nxt == 2'd0);

  always_ff @(posedge clk) begin
    if (rst) begin
      r_q0          <= '0;
      r_q1          <= '0;
      r_q_cnt       <= 2'd0;
      r_final_taken <= 1'b0;
    end else begin
      r_q_cnt <= w_q_cnt_nxt;
      if (w_stream_done) begin
        r_final_taken <= 1'b0;
      end else if (w_d_final) begin
        r_final_taken <= 1'b1;
      end
      if (w_out_fire) begin
        if (w_d_fire && (r_q_cnt == 2'd1)) begin
          r_q0 <= d;
        end else begin
          r_q0 <= r_q1;
        end
        if (w_d_fire && (r_q_cnt == 2'd2)) begin
          r_q1 <= d;
        end
      end else if (w_d_fire) begin
        if (r_q_cnt == 2'd0) begin
          r_q0 <= d;
        end else begin
          r_q1 <= d;
        end
      end
    end
  end
`else
  // Pass-through: the adapter sees the host word directly during STREAM.
  assign o__in         = d;
  assign o__in_isReady = w_stream & d_isReady;
  assign d_canReceive  = w_stream & o__in_canReceive;
  assign w_stream_done = w_d_final;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= ST_IDLE;
      r_size  <= '0;
      r_cnt   <= '0;
      r_err   <= 1'b0;
    end else begin
      if (w_err_set) begin
        r_err <= 1'b1;
      end
      case (r_state)
        ST_IDLE: begin
          if (w_desc_fire) begin
            r_size  <= desc;
            r_state <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          if (w_cmd_fire) begin
            r_cnt   <= r_size;
            r_state <= ST_STREAM;
          end
        end
        ST_STREAM: begin
          // Counter only moves in sized mode and never wraps below zero.
          if (w_d_fire && !w_auto && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_ONE;
          end
          if (w_stream_done) begin
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_outer_frame_sender.sv
module tb_outer_frame_sender;

  localparam int W = 15;

  logic          clk;
  logic          rst;
  logic [W-1:0]  desc;
  logic          desc_isReady;
  logic          desc_canReceive;
  logic [63:0]   d;
  logic          d_isReady;
  logic          d_canReceive;
  logic          d_isLast;
  logic [W-1:0]  cmd;
  logic          cmd_isReady;
  logic          cmd_canReceive;
  logic [63:0]   o__in;
  logic          o__in_isReady;
  logic          o__in_canReceive;
  logic          busy;
  logic          err;

  int tests;
  int fails;
  int n_dbeat;
  int n_cbeat;
  logic [63:0] beat_dat [0:15];

  outer_frame_sender #(.MAX_WORD_LEN(W)) dut (
    .clk              (clk),
    .rst              (rst),
    .desc             (desc),
    .desc_isReady     (desc_isReady),
    .desc_canReceive  (desc_canReceive),
    .d                (d),
    .d_isReady        (d_isReady),
    .d_canReceive     (d_canReceive),
    .d_isLast         (d_isLast),
    .cmd              (cmd),
    .cmd_isReady      (cmd_isReady),
    .cmd_canReceive   (cmd_canReceive),
    .o__in            (o__in),
    .o__in_isReady    (o__in_isReady),
    .o__in_canReceive (o__in_canReceive),
    .busy             (busy),
    .err              (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Beat monitor on the adapter side.
  always @(posedge clk) begin
    if (!rst) begin
      if (o__in_isReady && o__in_canReceive) begin
        if (n_dbeat < 16) beat_dat[n_dbeat] = o__in;
        n_dbeat = n_dbeat + 1;
      end
      if (cmd_isReady && cmd_canReceive) n_cbeat = n_cbeat + 1;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic clear_counts();
    n_dbeat = 0;
    n_cbeat = 0;
  endtask

  // Descriptor handshake then command accept; returns what the ISSUE cycle showed.
  task automatic start_xfer(input logic [W-1:0] size, output logic [W-1:0] cmd_seen, output logic rdy_seen);
    @(negedge clk);
    desc = size;
    desc_isReady = 1'b1;
    @(negedge clk);
    desc_isReady = 1'b0;
    #1;
    cmd_seen = cmd;
    rdy_seen = cmd_isReady;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", busy); end
    tests++; if (desc_canReceive !== 1'b1) begin fails++; $display("FAIL reset_desc_canReceive: got %0b want 1", desc_canReceive); end
    tests++; if (cmd_isReady !== 1'b0 || cmd !== '0) begin fails++; $display("FAIL reset_cmd: got rdy=%0b cmd=%0d want 0/0", cmd_isReady, cmd); end
    tests++; if (o__in_isReady !== 1'b0 || d_canReceive !== 1'b0) begin fails++; $display("FAIL reset_data: got o_rdy=%0b d_can=%0b want 0/0", o__in_isReady, d_canReceive); end
    tests++; if (err !== 1'b0) begin fails++; $display("FAIL reset_err: got %0b want 0", err); end
  endtask

  task automatic test_sized_basic();
    logic [63:0] words [0:2];
    words[0] = 64'hAAAA_0000_0000_0001;
    words[1] = 64'hBBBB_0000_0000_0002;
    words[2] = 64'hCCCC_0000_0000_0003;
    clear_counts();
    @(negedge clk);
    desc = 15'd3;
    desc_isReady = 1'b1;
    #1;
    tests++; if (desc_canReceive !== 1'b1) begin fails++; $display("FAIL t1_desc_accept: got %0b want 1", desc_canReceive); end
    @(negedge clk);
    desc_isReady = 1'b0;
    d_isReady = 1'b1;
    d = words[0];
    #1;
    tests++; if (cmd_isReady !== 1'b1 || cmd !== 15'd3) begin fails++; $display("FAIL t1_cmd: got rdy=%0b cmd=%0d want 1/3", cmd_isReady, cmd); end
    tests++; if (d_canReceive !== 1'b0 || o__in_isReady !== 1'b0) begin fails++; $display("FAIL t1_no_data_in_issue: got d_can=%0b o_rdy=%0b want 0/0", d_canReceive, o__in_isReady); end
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d = words[i];
      d_isReady = 1'b1;
      d_isLast = (i == 2);
      #1;
      tests++; if (o__in_isReady !== 1'b1 || o__in !== words[i] || d_canReceive !== 1'b1) begin fails++; $display("FAIL t1_beat%0d: got rdy=%0b dat=%h can=%0b want 1/%h/1", i, o__in_isReady, o__in, d_canReceive, words[i]); end
      tests++; if (cmd_isReady !== 1'b0) begin fails++; $display("FAIL t1_cmd_pulse%0d: got %0b want 0", i, cmd_isReady); end
    end
    @(negedge clk);
    d_isReady = 1'b0;
    d_isLast = 1'b0;
    #1;
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL t1_idle_after: got busy=%0b want 0", busy); end
    tests++; if (n_dbeat !== 3 || n_cbeat !== 1) begin fails++; $display("FAIL t1_counts: got data=%0d cmd=%0d want 3/1", n_dbeat, n_cbeat); end
    tests++; if (beat_dat[0] !== words[0] || beat_dat[1] !== words[1] || beat_dat[2] !== words[2]) begin fails++; $display("FAIL t1_order: got %h %h %h", beat_dat[0], beat_dat[1], beat_dat[2]); end
  endtask

  task automatic test_stall();
    logic [W-1:0] cs;
    logic rs;
    clear_counts();
    start_xfer(15'd2, cs, rs);
    tests++; if (rs !== 1'b1 || cs !== 15'd2) begin fails++; $display("FAIL t2_cmd: got rdy=%0b cmd=%0d want 1/2", rs, cs); end
    @(negedge clk);
    d = 64'h1111_2222_3333_4444;
    d_isReady = 1'b1;
    o__in_canReceive = 1'b1;
    #1;
    tests++; if (d_canReceive !== 1'b1) begin fails++; $display("FAIL t2_first_can: got %0b want 1", d_canReceive); end
    @(negedge clk);
    d = 64'h5555_6666_7777_8888;
    o__in_canReceive = 1'b0;
    #1;
    tests++; if (d_canReceive !== 1'b0 || o__in_isReady !== 1'b1 || o__in !== 64'h5555_6666_7777_8888) begin fails++; $display("FAIL t2_stall: got can=%0b rdy=%0b dat=%h", d_canReceive, o__in_isReady, o__in); end
    @(negedge clk);
    o__in_canReceive = 1'b1;
    #1;
    tests++; if (o__in !== 64'h5555_6666_7777_8888 || d_canReceive !== 1'b1 || n_dbeat !== 1) begin fails++; $display("FAIL t2_resume: got dat=%h can=%0b beats=%0d want held/1/1", o__in, d_canReceive, n_dbeat); end
    @(negedge clk);
    o__in_canReceive = 1'b0;
    d = 64'h9999_9999_9999_9999;
    #1;
    tests++; if (busy !== 1'b0 || o__in_isReady !== 1'b0 || n_dbeat !== 2) begin fails++; $display("FAIL t2_end: got busy=%0b rdy=%0b beats=%0d want 0/0/2", busy, o__in_isReady, n_dbeat); end
    tests++; if (beat_dat[1] !== 64'h5555_6666_7777_8888) begin fails++; $display("FAIL t2_second_word: got %h", beat_dat[1]); end
    @(negedge clk);
    d_isReady = 1'b0;
    o__in_canReceive = 1'b1;
  endtask

  task automatic test_auto_mode();
    logic [W-1:0] cs;
    logic rs;
    clear_counts();
    start_xfer(15'd0, cs, rs);
    tests++; if (rs !== 1'b1 || cs !== 15'd0) begin fails++; $display("FAIL t3_cmd: got rdy=%0b cmd=%0d want 1/0", rs, cs); end
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      d = 64'h3000 + 64'(i);
      d_isReady = 1'b1;
      d_isLast = (i == 4);
      #1;
      tests++; if (d_canReceive !== 1'b1 || o__in_isReady !== 1'b1) begin fails++; $display("FAIL t3_word%0d: got can=%0b rdy=%0b want 1/1", i, d_canReceive, o__in_isReady); end
    end
    @(negedge clk);
    d = 64'h3005;
    d_isLast = 1'b0;
    #1;
    tests++; if (d_canReceive !== 1'b0 || busy !== 1'b0) begin fails++; $display("FAIL t3_sixth_refused: got can=%0b busy=%0b want 0/0", d_canReceive, busy); end
    @(negedge clk);
    #1;
    tests++; if (n_dbeat !== 5 || beat_dat[4] !== 64'h3004) begin fails++; $display("FAIL t3_beats: got %0d last=%h want 5/3004", n_dbeat, beat_dat[4]); end
    d_isReady = 1'b0;
  endtask

  task automatic test_early_last();
    logic [W-1:0] cs;
    logic rs;
    clear_counts();
    start_xfer(15'd4, cs, rs);
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      d = 64'h4000 + 64'(i);
      d_isReady = 1'b1;
      d_isLast = (i == 1);
      #1;
      if (i == 1) begin
        tests++; if (err !== 1'b0) begin fails++; $display("FAIL t4_err_before: got %0b want 0", err); end
      end
      if (i == 2) begin
        tests++; if (err !== 1'b1 || d_canReceive !== 1'b1) begin fails++; $display("FAIL t4_err_set: got err=%0b can=%0b want 1/1", err, d_canReceive); end
      end
    end
    @(negedge clk);
    d_isReady = 1'b0;
    d_isLast = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || n_dbeat !== 4) begin fails++; $display("FAIL t4_full_count: got busy=%0b beats=%0d want 0/4", busy, n_dbeat); end
    @(negedge clk);
    #1;
    tests++; if (err !== 1'b1) begin fails++; $display("FAIL t4_err_sticky: got %0b want 1", err); end
  endtask

  task automatic test_cmd_backpressure();
    clear_counts();
    @(negedge clk);
    cmd_canReceive = 1'b0;
    desc = 15'd7;
    desc_isReady = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      desc_isReady = 1'b0;
      d = 64'h5000;
      d_isReady = 1'b1;
      #1;
      tests++; if (cmd !== 15'd7 || cmd_isReady !== 1'b1 || d_canReceive !== 1'b0 || o__in_isReady !== 1'b0) begin fails++; $display("FAIL t5_hold%0d: got cmd=%0d rdy=%0b can=%0b o_rdy=%0b want 7/1/0/0", i, cmd, cmd_isReady, d_canReceive, o__in_isReady); end
    end
    @(negedge clk);
    cmd_canReceive = 1'b1;
    for (int i = 0; i < 7; i++) begin
      @(negedge clk);
      d = 64'h5000 + 64'(i);
    end
    @(negedge clk);
    d_isReady = 1'b0;
    #1;
    tests++; if (n_cbeat !== 1 || n_dbeat !== 7 || busy !== 1'b0) begin fails++; $display("FAIL t5_complete: got cmd=%0d data=%0d busy=%0b want 1/7/0", n_cbeat, n_dbeat, busy); end
    tests++; if (n_dbeat > 6 && beat_dat[6] !== 64'h5006) begin fails++; $display("FAIL t5_last_word: got %h want 5006", beat_dat[6]); end
  endtask

  task automatic test_reset_mid_stream();
    logic [W-1:0] cs;
    logic rs;
    clear_counts();
    start_xfer(15'd10, cs, rs);
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      d = 64'h6000 + 64'(i);
      d_isReady = 1'b1;
    end
    @(negedge clk);
    #1;
    tests++; if (n_dbeat !== 3 || busy !== 1'b1) begin fails++; $display("FAIL t6_pre: got beats=%0d busy=%0b want 3/1", n_dbeat, busy); end
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || err !== 1'b0) begin fails++; $display("FAIL t6_reset_state: got busy=%0b err=%0b want 0/0", busy, err); end
    tests++; if (cmd_isReady !== 1'b0 || o__in_isReady !== 1'b0 || d_canReceive !== 1'b0 || desc_canReceive !== 1'b1) begin fails++; $display("FAIL t6_reset_hs: got cmd=%0b o=%0b dcan=%0b desc=%0b want 0/0/0/1", cmd_isReady, o__in_isReady, d_canReceive, desc_canReceive); end
    d_isReady = 1'b0;
    clear_counts();
    start_xfer(15'd1, cs, rs);
    tests++; if (rs !== 1'b1 || cs !== 15'd1) begin fails++; $display("FAIL t6_new_cmd: got rdy=%0b cmd=%0d want 1/1", rs, cs); end
    @(negedge clk);
    d = 64'hFEED_FACE_0000_0001;
    d_isReady = 1'b1;
    @(negedge clk);
    d_isReady = 1'b0;
    #1;
    tests++; if (busy !== 1'b0 || n_dbeat !== 1 || beat_dat[0] !== 64'hFEED_FACE_0000_0001) begin fails++; $display("FAIL t6_new_xfer: got busy=%0b beats=%0d dat=%h", busy, n_dbeat, beat_dat[0]); end
  endtask

  initial begin
    tests = 0;
    fails = 0;
    n_dbeat = 0;
    n_cbeat = 0;
    rst = 1'b1;
    desc = '0;
    desc_isReady = 1'b0;
    d = '0;
    d_isReady = 1'b0;
    d_isLast = 1'b0;
    cmd_canReceive = 1'b1;
    o__in_canReceive = 1'b1;
    test_reset();
    test_sized_basic();
    test_stall();
    test_auto_mode();
    test_early_last();
    test_cmd_backpressure();
    test_reset_mid_stream();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
